// File: rtl/aexm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aexm_pkg
//  Description : Shared constants for the load/store stage: opcode fields,
//                transfer sizes, byte-lane selects and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aexm_pkg;

    // Opcode major field rOPC[5:4] for load/store instructions
    localparam logic [1:0] OPC_MEM  = 2'b11;

    // Transfer size in rOPC[1:0]; code 3 is the FSL channel, not memory
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_FSL   = 2'd3;

    // Byte-lane selects (big-endian lane numbering on the bus)
    localparam logic [3:0] SEL_NONE = 4'h0;
    localparam logic [3:0] SEL_B0   = 4'h8;
    localparam logic [3:0] SEL_B1   = 4'h4;
    localparam logic [3:0] SEL_B2   = 4'h2;
    localparam logic [3:0] SEL_B3   = 4'h1;
    localparam logic [3:0] SEL_HHI  = 4'hC;
    localparam logic [3:0] SEL_HLO  = 4'h3;
    localparam logic [3:0] SEL_WORD = 4'hF;

    // Bus-cycle state machine
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } memu_state_e;

endpackage
`default_nettype wire

// File: rtl/aexm_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : aexm_lane_align
//  Description : Combinational lane steering. Load side right-justifies and
//                zero-extends the selected bus lanes; store side replicates
//                the operand across all lanes according to transfer size.
//  Revision    : 1.0 - initial release
// ============================================================================
module aexm_lane_align
    import aexm_pkg::*;
(
    input  logic [3:0]  sel_i,
    input  logic [31:0] bus_dat_i,
    output logic [31:0] load_dat_o,
    input  logic [1:0]  size_i,
    input  logic [31:0] store_dat_i,
    output logic [31:0] bus_dat_o
);

    // Load aligner: pick the addressed lanes, place them at bit 0, zero the rest
    always_comb begin
        load_dat_o = 32'h0;
        case (sel_i)
            SEL_B0:   load_dat_o = {24'h0, bus_dat_i[31:24]};
            SEL_B1:   load_dat_o = {24'h0, bus_dat_i[23:16]};
            SEL_B2:   load_dat_o = {24'h0, bus_dat_i[15:8]};
            SEL_B3:   load_dat_o = {24'h0, bus_dat_i[7:0]};
            SEL_HHI:  load_dat_o = {16'h0, bus_dat_i[31:16]};
            SEL_HLO:  load_dat_o = {16'h0, bus_dat_i[15:0]};
            SEL_WORD: load_dat_o = bus_dat_i;
            default:  load_dat_o = 32'h0;
        endcase
    end

    // Store replicator: the slave picks its lanes via sel, so copy to every lane
    always_comb begin
        bus_dat_o = store_dat_i;
        case (size_i)
            SZ_BYTE: bus_dat_o = {4{store_dat_i[7:0]}};
            SZ_HALF: bus_dat_o = {2{store_dat_i[15:0]}};
            default: bus_dat_o = store_dat_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aexm_memu.sv
`default_nettype none
// ============================================================================
//  Module      : aexm_memu
//  Description : Load/store stage. Launches a single data-bus cycle per
//                memory instruction, stalls execute while it is outstanding,
//                aborts on timeout and returns aligned load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module aexm_memu
    import aexm_pkg::*;
#(
    parameter int DW  = 32,
    parameter int TMO = 15
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          x_en,
    input  logic [31:0]   rRESULT,
    input  logic [3:0]    rDWBSEL,
    input  logic [5:0]    rOPC,
    input  logic [31:0]   rREGD,
    input  logic [4:0]    rRD,
    output logic [DW-3:0] dwb_adr_o,
    output logic [31:0]   dwb_dat_o,
    output logic [3:0]    dwb_sel_o,
    output logic          dwb_stb_o,
    output logic          dwb_wre_o,
    input  logic          dwb_ack_i,
    input  logic [31:0]   dwb_dat_i,
    output logic          dSTALL,
    output logic [31:0]   rDWBDI,
    output logic          rLDV,
    output logic [4:0]    rLDRD,
    output logic          rDERR
);

    localparam logic [7:0] TMO_LIMIT = 8'(TMO);

    memu_state_e   state_q, state_d;
    logic [DW-3:0] adr_q,   adr_d;
    logic [31:0]   dat_q,   dat_d;
    logic [3:0]    sel_q,   sel_d;
    logic          stb_q,   stb_d;
    logic          wre_q,   wre_d;
    logic [31:0]   dbi_q,   dbi_d;
    logic          ldv_q,   ldv_d;
    logic [4:0]    ldrd_q,  ldrd_d;
    logic          derr_q,  derr_d;
    logic [7:0]    cnt_q,   cnt_d;

    logic          w_memop;
    logic          w_tmo_hit;
    logic [31:0]   w_load_dat;
    logic [31:0]   w_store_dat;
    logic          w_unused_bits;

    aexm_lane_align u_lane_align (
        .sel_i       (sel_q),
        .bus_dat_i   (dwb_dat_i),
        .load_dat_o  (w_load_dat),
        .size_i      (rOPC[1:0]),
        .store_dat_i (rREGD),
        .bus_dat_o   (w_store_dat)
    );

    // A zero byte-select or the FSL size code never reaches the data bus
    assign w_memop   = (rOPC[5:4] == OPC_MEM) && (rOPC[1:0] != SZ_FSL) &&
                       (rDWBSEL != SEL_NONE);
    // True in the BUSY cycle that would bring the counter up to the limit
    assign w_tmo_hit = (({1'b0, cnt_q} + 9'd1) >= {1'b0, TMO_LIMIT});

    // Word-offset address bits and opcode bit 3 carry no meaning here
    assign w_unused_bits = ^{rRESULT[1:0], rOPC[3]};

    // Next-state logic: launch, complete, or abort the single bus cycle
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        stb_d   = stb_q;
        wre_d   = wre_q;
        dbi_d   = dbi_q;
        ldv_d   = 1'b0;
        ldrd_d  = ldrd_q;
        derr_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (x_en && w_memop) begin
                    state_d = ST_BUSY;
                    adr_d   = rRESULT[DW-1:2];
                    dat_d   = w_store_dat;
                    sel_d   = rDWBSEL;
                    wre_d   = rOPC[2];
                    ldrd_d  = rRD;
                    stb_d   = 1'b1;
                    cnt_d   = 8'h0;
                end
            end
            ST_BUSY: begin
                // Ack wins over a timeout that would fire in the same cycle
                if (dwb_ack_i) begin
                    state_d = ST_IDLE;
                    stb_d   = 1'b0;
                    if (!wre_q) begin
                        dbi_d = w_load_dat;
                        ldv_d = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    state_d = ST_IDLE;
                    stb_d   = 1'b0;
                    derr_d  = 1'b1;
                    dbi_d   = 32'h0;
                    cnt_d   = TMO_LIMIT;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge gclk) begin
        if (!grst) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= 32'h0;
            sel_q   <= 4'h0;
            stb_q   <= 1'b0;
            wre_q   <= 1'b0;
            dbi_q   <= 32'h0;
            ldv_q   <= 1'b0;
            ldrd_q  <= 5'h0;
            derr_q  <= 1'b0;
            cnt_q   <= 8'h0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            wre_q   <= wre_d;
            dbi_q   <= dbi_d;
            ldv_q   <= ldv_d;
            ldrd_q  <= ldrd_d;
            derr_q  <= derr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dwb_adr_o = adr_q;
    assign dwb_dat_o = dat_q;
    assign dwb_sel_o = sel_q;
    assign dwb_stb_o = stb_q;
    assign dwb_wre_o = wre_q;
    assign dSTALL    = stb_q & ~dwb_ack_i;
    assign rDWBDI    = dbi_q;
    assign rLDV      = ldv_q;
    assign rLDRD     = ldrd_q;
    assign rDERR     = derr_q;

endmodule
`default_nettype wire

// File: tb/tb_aexm_memu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_aexm_memu
//  Description : Self-checking bench for the load/store stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aexm_memu;

    localparam int DW  = 32;
    localparam int TMO = 15;

    localparam logic [5:0] OP_LBU = 6'b110000;
    localparam logic [5:0] OP_LHU = 6'b110001;
    localparam logic [5:0] OP_LW  = 6'b110010;
    localparam logic [5:0] OP_SH  = 6'b110101;
    localparam logic [5:0] OP_SW  = 6'b110110;
    localparam logic [5:0] OP_FSL = 6'b110011;

    logic          gclk = 1'b0;
    logic          grst = 1'b0;
    logic          x_en = 1'b0;
    logic [31:0]   rRESULT = 32'h0;
    logic [3:0]    rDWBSEL = 4'h0;
    logic [5:0]    rOPC = 6'h0;
    logic [31:0]   rREGD = 32'h0;
    logic [4:0]    rRD = 5'h0;
    logic [DW-3:0] dwb_adr_o;
    logic [31:0]   dwb_dat_o;
    logic [3:0]    dwb_sel_o;
    logic          dwb_stb_o;
    logic          dwb_wre_o;
    logic          dwb_ack_i = 1'b0;
    logic [31:0]   dwb_dat_i = 32'h0;
    logic          dSTALL;
    logic [31:0]   rDWBDI;
    logic          rLDV;
    logic [4:0]    rLDRD;
    logic          rDERR;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_dbi  = 32'h0;
    int            stb_starts = 0;
    logic          stb_prev = 1'b0;

    always #5 gclk = ~gclk;

    aexm_memu #(.DW(DW), .TMO(TMO)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .x_en      (x_en),
        .rRESULT   (rRESULT),
        .rDWBSEL   (rDWBSEL),
        .rOPC      (rOPC),
        .rREGD     (rREGD),
        .rRD       (rRD),
        .dwb_adr_o (dwb_adr_o),
        .dwb_dat_o (dwb_dat_o),
        .dwb_sel_o (dwb_sel_o),
        .dwb_stb_o (dwb_stb_o),
        .dwb_wre_o (dwb_wre_o),
        .dwb_ack_i (dwb_ack_i),
        .dwb_dat_i (dwb_dat_i),
        .dSTALL    (dSTALL),
        .rDWBDI    (rDWBDI),
        .rLDV      (rLDV),
        .rLDRD     (rLDRD),
        .rDERR     (rDERR)
    );

    // Count bus strobes started (rising edges of stb)
    always @(posedge gclk) begin
        stb_prev <= dwb_stb_o;
        if (dwb_stb_o && !stb_prev) stb_starts <= stb_starts + 1;
    end

    // Reference: selected lanes, taken from the lowest selected byte upward
    function automatic logic [31:0] ref_load(input logic [3:0] sel, input logic [31:0] d);
        int          n;
        int          lsb;
        logic [63:0] mask;
        n = 0;
        lsb = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) n++;
        for (int i = 3; i >= 0; i--) if (sel[i]) lsb = i;
        mask = (64'd1 << (8 * n)) - 64'd1;
        return (d >> (8 * lsb)) & mask[31:0];
    endfunction

    // Reference: operand copied into every lane of its size
    function automatic logic [31:0] ref_store(input logic [1:0] sz, input logic [31:0] v);
        if (sz == 2'd0) return 32'(v[7:0]) * 32'h01010101;
        if (sz == 2'd1) return 32'(v[15:0]) * 32'h00010001;
        return v;
    endfunction

    // Drive one memory instruction, answer after 'waits' wait cycles
    // (waits >= TMO means never), and check the bus cycle and writeback.
    task automatic run_op(input string nm, input logic [5:0] opc, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] regd, input logic [4:0] rd,
                          input int waits, input logic [31:0] din);
        int   stalls;
        bit   acked;
        logic is_store;
        stalls   = 0;
        acked    = 1'b0;
        is_store = opc[2];
        @(negedge gclk);
        x_en = 1'b1; rOPC = opc; rRESULT = addr; rDWBSEL = sel; rREGD = regd; rRD = rd;
        dwb_ack_i = 1'b0;
        @(negedge gclk);
        x_en = 1'b0; rOPC = 6'h0; rDWBSEL = 4'h0;
        n_checks++;
        if (dwb_stb_o !== 1'b1 || dwb_wre_o !== is_store || dwb_sel_o !== sel) begin
            n_fail++;
            $display("FAIL %s launch: stb=%b wre=%b sel=%h, required stb=1 wre=%b sel=%h",
                     nm, dwb_stb_o, dwb_wre_o, dwb_sel_o, is_store, sel);
        end
        n_checks++;
        if (dwb_adr_o !== addr[31:2] || dwb_dat_o !== ref_store(opc[1:0], regd)) begin
            n_fail++;
            $display("FAIL %s bus adr/dat: got %h/%h, required %h/%h", nm, dwb_adr_o, dwb_dat_o,
                     addr[31:2], ref_store(opc[1:0], regd));
        end
        for (int c = 0; c < TMO && !acked; c++) begin
            if (c == waits) begin
                dwb_ack_i = 1'b1; dwb_dat_i = din; acked = 1'b1;
            end else begin
                dwb_dat_i = $urandom;
            end
            #1;
            if (dSTALL) stalls++;
            n_checks++;
            if (dwb_stb_o !== 1'b1 || dwb_adr_o !== addr[31:2]) begin
                n_fail++;
                $display("FAIL %s busy hold cycle %0d: stb=%b adr=%h, required 1/%h",
                         nm, c, dwb_stb_o, dwb_adr_o, addr[31:2]);
            end
            @(negedge gclk);
        end
        dwb_ack_i = 1'b0;
        if (!acked) exp_dbi = 32'h0;
        else if (!is_store) exp_dbi = ref_load(sel, din);
        n_checks++;
        if (dwb_stb_o !== 1'b0 || rLDV !== (acked && !is_store) || rDERR !== !acked) begin
            n_fail++;
            $display("FAIL %s end: stb=%b ldv=%b derr=%b, required 0/%b/%b",
                     nm, dwb_stb_o, rLDV, rDERR, acked && !is_store, !acked);
        end
        n_checks++;
        if (rDWBDI !== exp_dbi || rLDRD !== rd) begin
            n_fail++;
            $display("FAIL %s data: rDWBDI=%h rLDRD=%0d, required %h/%0d", nm, rDWBDI, rLDRD, exp_dbi, rd);
        end
        n_checks++;
        if (stalls != (acked ? waits : TMO)) begin
            n_fail++;
            $display("FAIL %s stall cycles: got %0d, required %0d", nm, stalls, acked ? waits : TMO);
        end
        @(negedge gclk);
        n_checks++;
        if (rLDV !== 1'b0 || rDERR !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse width: ldv=%b derr=%b, required 0/0", nm, rLDV, rDERR);
        end
    endtask

    task automatic test_reset;
        grst = 1'b0;
        repeat (3) @(negedge gclk);
        n_checks++;
        if (dwb_stb_o !== 1'b0 || dwb_wre_o !== 1'b0 || dwb_sel_o !== 4'h0 || dwb_adr_o !== '0 ||
            dwb_dat_o !== 32'h0 || rDWBDI !== 32'h0 || rLDV !== 1'b0 || rLDRD !== 5'h0 ||
            rDERR !== 1'b0 || dSTALL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: stb=%b wre=%b sel=%h adr=%h dat=%h dbi=%h ldv=%b rd=%0d derr=%b stall=%b, required all 0",
                     dwb_stb_o, dwb_wre_o, dwb_sel_o, dwb_adr_o, dwb_dat_o, rDWBDI, rLDV, rLDRD, rDERR, dSTALL);
        end
        grst = 1'b1;
        exp_dbi = 32'h0;
    endtask

    task automatic test_non_memory;
        int s0;
        @(negedge gclk);
        s0 = stb_starts;
        x_en = 1'b1; rOPC = OP_FSL; rDWBSEL = 4'hF; rRESULT = 32'h100;
        @(negedge gclk);
        rOPC = OP_LW; rDWBSEL = 4'h0;
        @(negedge gclk);
        rOPC = 6'b000010; rDWBSEL = 4'hF;
        @(negedge gclk);
        x_en = 1'b0; rOPC = OP_LW;
        dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFFFFFF;
        @(negedge gclk);
        dwb_ack_i = 1'b0; rOPC = 6'h0; rDWBSEL = 4'h0;
        repeat (2) @(negedge gclk);
        n_checks++;
        if (stb_starts != s0 || dwb_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL non-memory strobes: got %0d stb=%b, required 0/0", stb_starts - s0, dwb_stb_o);
        end
        n_checks++;
        if (rLDV !== 1'b0 || rDWBDI !== exp_dbi) begin
            n_fail++;
            $display("FAIL idle ack: ldv=%b dbi=%h, required 0/%h", rLDV, rDWBDI, exp_dbi);
        end
    endtask

    task automatic test_lbu;
        run_op("lbu_waits2", OP_LBU, 32'h00001001, 4'h4, 32'h0, 5'd7, 2, 32'h11223344);
        n_checks++;
        if (rDWBDI !== 32'h00000022) begin
            n_fail++;
            $display("FAIL lbu value: got %h, required 00000022", rDWBDI);
        end
    endtask

    task automatic test_sh;
        run_op("sh_zero_wait", OP_SH, 32'h00000042, 4'h3, 32'hDEADBEEF, 5'd4, 0, 32'h0);
        n_checks++;
        if (dwb_dat_o !== 32'hBEEFBEEF) begin
            n_fail++;
            $display("FAIL sh data: got %h, required BEEFBEEF", dwb_dat_o);
        end
    endtask

    task automatic test_lw_lhu;
        run_op("lw", OP_LW, 32'h00000100, 4'hF, 32'h0, 5'd1, 1, 32'hCAFEF00D);
        n_checks++;
        if (rDWBDI !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL lw value: got %h, required CAFEF00D", rDWBDI);
        end
        run_op("lhu_hi", OP_LHU, 32'h00000100, 4'hC, 32'h0, 5'd2, 0, 32'hCAFEF00D);
        n_checks++;
        if (rDWBDI !== 32'h0000CAFE) begin
            n_fail++;
            $display("FAIL lhu value: got %h, required 0000CAFE", rDWBDI);
        end
    endtask

    task automatic test_timeout;
        run_op("timeout", OP_LW, 32'h0000F000, 4'hF, 32'h0, 5'd5, 1000, 32'h0);
        n_checks++;
        if (rDWBDI !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout data: got %h, required 00000000", rDWBDI);
        end
        run_op("ack_at_limit", OP_LW, 32'h0000F004, 4'hF, 32'h0, 5'd6, TMO - 1, 32'h5A5A1234);
    endtask

    task automatic test_reset_busy;
        @(negedge gclk);
        x_en = 1'b1; rOPC = OP_LW; rRESULT = 32'h00000200; rDWBSEL = 4'hF; rRD = 5'd11;
        @(negedge gclk);
        x_en = 1'b0; rOPC = 6'h0;
        grst = 1'b0;
        @(negedge gclk);
        n_checks++;
        if (dwb_stb_o !== 1'b0 || dwb_sel_o !== 4'h0 || dwb_adr_o !== '0 || rDWBDI !== 32'h0 ||
            rLDRD !== 5'h0 || rLDV !== 1'b0 || rDERR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset in busy: stb=%b sel=%h adr=%h dbi=%h rd=%0d ldv=%b derr=%b, required all 0",
                     dwb_stb_o, dwb_sel_o, dwb_adr_o, rDWBDI, rLDRD, rLDV, rDERR);
        end
        grst = 1'b1; exp_dbi = 32'h0;
        dwb_ack_i = 1'b1; dwb_dat_i = 32'h87654321;
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        n_checks++;
        if (rLDV !== 1'b0 || rDWBDI !== 32'h0 || dwb_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late ack: ldv=%b dbi=%h stb=%b, required 0/0/0", rLDV, rDWBDI, dwb_stb_o);
        end
    endtask

    task automatic test_back_to_back;
        int s0;
        @(negedge gclk);
        s0 = stb_starts;
        x_en = 1'b1; rOPC = OP_SW; rRESULT = 32'h00002000; rDWBSEL = 4'hF; rREGD = 32'h12345678; rRD = 5'd3;
        @(negedge gclk);
        n_checks++;
        if (dwb_stb_o !== 1'b1 || dwb_wre_o !== 1'b1 || dwb_adr_o !== 30'h800 || dwb_dat_o !== 32'h12345678) begin
            n_fail++;
            $display("FAIL b2b sw: stb=%b wre=%b adr=%h dat=%h, required 1/1/800/12345678",
                     dwb_stb_o, dwb_wre_o, dwb_adr_o, dwb_dat_o);
        end
        rOPC = OP_LBU; rRESULT = 32'h00003003; rDWBSEL = 4'h8; rRD = 5'd9;
        dwb_ack_i = 1'b1;
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        n_checks++;
        if (dwb_stb_o !== 1'b0 || rLDV !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b sw done: stb=%b ldv=%b, required 0/0", dwb_stb_o, rLDV);
        end
        @(negedge gclk);
        n_checks++;
        if (dwb_stb_o !== 1'b1 || dwb_wre_o !== 1'b0 || dwb_adr_o !== 30'hC00 || dwb_sel_o !== 4'h8) begin
            n_fail++;
            $display("FAIL b2b lbu: stb=%b wre=%b adr=%h sel=%h, required 1/0/C00/8",
                     dwb_stb_o, dwb_wre_o, dwb_adr_o, dwb_sel_o);
        end
        rOPC = OP_FSL; rDWBSEL = 4'hF;
        dwb_ack_i = 1'b1; dwb_dat_i = 32'hA1B2C3D4;
        @(negedge gclk);
        dwb_ack_i = 1'b0;
        exp_dbi = ref_load(4'h8, 32'hA1B2C3D4);
        n_checks++;
        if (rLDV !== 1'b1 || rDERR !== 1'b0 || rDWBDI !== exp_dbi || rLDRD !== 5'd9) begin
            n_fail++;
            $display("FAIL b2b lbu done: ldv=%b derr=%b dbi=%h rd=%0d, required 1/0/%h/9",
                     rLDV, rDERR, rDWBDI, rLDRD, exp_dbi);
        end
        repeat (3) @(negedge gclk);
        x_en = 1'b0; rOPC = 6'h0; rDWBSEL = 4'h0;
        n_checks++;
        if (stb_starts - s0 != 2 || dwb_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b strobe count: got %0d stb=%b, required 2/0", stb_starts - s0, dwb_stb_o);
        end
    endtask

    task automatic test_random;
        logic [5:0]  opc;
        logic [3:0]  sel;
        logic [1:0]  sz;
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom_range(0, 2));
            if (sz == 2'd0)      sel = 4'(1 << $urandom_range(0, 3));
            else if (sz == 2'd1) sel = ($urandom_range(0, 1) != 0) ? 4'hC : 4'h3;
            else                 sel = 4'hF;
            opc = {2'b11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz};
            run_op("random", opc, $urandom, sel, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 4), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_non_memory();
        test_lbu();
        test_sh();
        test_lw_lhu();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge gclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
